// File: rtl/mcu_gpio_bridge.sv
// mcu_gpio_bridge
// Bridges the MCU 8-bit strobed parallel bus (four-phase mcu_mstr handshake)
// to a bank of PINS general-purpose pins. Each 8-pin bank exposes four byte
// registers selected by address = {sel[1:0], bank}:
//   sel 0 IN   : synchronised pins_in (read-only)
//   sel 1 OUT  : pad output values (R/W)
//   sel 2 DIR  : pad output enables, 1 = drive (R/W)
//   sel 3 PEND : edge-interrupt pending bits (read, write-1-to-clear)
// The top level owns the tristate buffers; this block only produces split
// in/out/oe signals.
//
// Ports:
//   CLK50        system clock
//   rst_n        asynchronous active-low reset
//   address      register select, held stable by the MCU while mcu_mstr=1
//   mcu_mstr     asynchronous MCU access strobe
//   write_enable 1 = write, 0 = read
//   data_in      MCU write data
//   data_out     read data to the MCU
//   data_oe      top level drives the MCU data bus when 1
//   fpga_ready   block idle, accepting a new access
//   fpga_ack     access complete
//   irq          registered OR of all pending bits
//   pins_in      raw pad inputs (asynchronous)
//   pins_out     pad output values
//   pins_oe      pad output enables
module mcu_gpio_bridge #(
    parameter int PINS        = 132,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK50,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              mcu_mstr,
    input  logic              write_enable,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              fpga_ready,
    output logic              fpga_ack,
    output logic              irq,
    input  logic [PINS-1:0]   pins_in,
    output logic [PINS-1:0]   pins_out,
    output logic [PINS-1:0]   pins_oe
);

    localparam int BANKS  = (PINS + 7) / 8;
    localparam int PAD_W  = BANKS * 8;
    localparam int BANK_W = ADDR_W - 2;
    localparam int CNT_W  = $clog2(SYNC_STAGES + 2);

    if (BANKS > (1 << BANK_W)) begin : g_bank_check
        $error("mcu_gpio_bridge: PINS needs more banks than ADDR_W can address");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("mcu_gpio_bridge: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Bits of a bank that map onto real pins; the tail of the last bank is 0.
    function automatic logic [7:0] valid_mask(input int bank);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = ((bank * 8 + i) < PINS);
        end
        return m;
    endfunction

    logic [1:0]             rst_sync_r;
    logic                   rst_int_n_s;
    logic [SYNC_STAGES-1:0] mstr_sync_r;
    logic                   mstr_s;
    logic [PINS-1:0]        in_sync_r [SYNC_STAGES];
    logic [PINS-1:0]        in_s;
    logic [PAD_W-1:0]       in_pad_s;
    logic [PAD_W-1:0]       in_prev_r;
    logic [CNT_W-1:0]       mask_cnt_r;
    logic                   edge_en_s;
    logic [PAD_W-1:0]       edge_s;

    state_t                 state_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   we_r;
    logic                   ack_r;
    logic                   oe_r;
    logic                   ready_r;
    logic [7:0]             rdata_r;

    logic [PAD_W-1:0]       out_r;
    logic [PAD_W-1:0]       dir_r;
    logic [PAD_W-1:0]       pend_r;
    logic                   irq_r;

    logic [1:0]             sel_s;
    logic [BANK_W-1:0]      bank_s;
    logic                   bank_ok_s;
    int                     bidx_s;
    logic [7:0]             byte_mask_s;
    logic                   wr_s;
    logic [PAD_W-1:0]       wr_mask_vec_s;
    logic [PAD_W-1:0]       wr_data_vec_s;
    logic [PAD_W-1:0]       clr_s;
    logic [7:0]             rd_byte_s;

    // Reset synchroniser: assertion is immediate, release is aligned to CLK50.
    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Strobe synchroniser chain.
    always_ff @(posedge CLK50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            mstr_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mstr_sync_r <= {mstr_sync_r[SYNC_STAGES-2:0], mcu_mstr};
        end
    end

    assign mstr_s = mstr_sync_r[SYNC_STAGES-1];

    // Pad input synchroniser chain.
    always_ff @(posedge CLK50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                in_sync_r[k] <= {PINS{1'b0}};
            end
        end else begin
            in_sync_r[0] <= pins_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                in_sync_r[k] <= in_sync_r[k-1];
            end
        end
    end

    assign in_s     = in_sync_r[SYNC_STAGES-1];
    assign in_pad_s = PAD_W'(in_s);

    // Edge-detect history and post-reset mask counter. The chain flushes
    // reset zeros for SYNC_STAGES+1 cycles; edges seen then are not real.
    always_ff @(posedge CLK50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            in_prev_r  <= {PAD_W{1'b0}};
            mask_cnt_r <= {CNT_W{1'b0}};
        end else begin
            in_prev_r <= in_pad_s;
            if (!edge_en_s) begin
                mask_cnt_r <= mask_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign edge_en_s = (mask_cnt_r == CNT_W'(SYNC_STAGES + 1));
    assign edge_s    = edge_en_s ? (in_pad_s ^ in_prev_r) : {PAD_W{1'b0}};

    // Decode of the captured access into byte lane masks and read data.
    always_comb begin
        sel_s         = addr_r[ADDR_W-1 -: 2];
        bank_s        = addr_r[BANK_W-1:0];
        bank_ok_s     = (int'(bank_s) < BANKS);
        bidx_s        = 0;
        byte_mask_s   = 8'h00;
        wr_mask_vec_s = {PAD_W{1'b0}};
        wr_data_vec_s = {PAD_W{1'b0}};
        clr_s         = {PAD_W{1'b0}};
        rd_byte_s     = 8'h00;
        wr_s          = (state_r == ST_ACCESS) && we_r;
        if (bank_ok_s) begin
            bidx_s      = int'(bank_s);
            byte_mask_s = valid_mask(int'(bank_s));
        end else begin
            bidx_s      = 0;
            byte_mask_s = 8'h00;
        end
        wr_mask_vec_s[bidx_s*8 +: 8] = byte_mask_s;
        wr_data_vec_s[bidx_s*8 +: 8] = data_in & byte_mask_s;
        if (wr_s && (sel_s == 2'd3)) begin
            clr_s = wr_data_vec_s;
        end else begin
            clr_s = {PAD_W{1'b0}};
        end
        case (sel_s)
            2'd0:    rd_byte_s = in_pad_s[bidx_s*8 +: 8] & byte_mask_s;
            2'd1:    rd_byte_s = out_r[bidx_s*8 +: 8]    & byte_mask_s;
            2'd2:    rd_byte_s = dir_r[bidx_s*8 +: 8]    & byte_mask_s;
            2'd3:    rd_byte_s = pend_r[bidx_s*8 +: 8]   & byte_mask_s;
            default: rd_byte_s = 8'h00;
        endcase
    end

    // Access FSM: capture, one-cycle access, hold ack until strobe drops.
    always_ff @(posedge CLK50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            ack_r   <= 1'b0;
            oe_r    <= 1'b0;
            ready_r <= 1'b0;
            rdata_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mstr_s) begin
                        addr_r  <= address;
                        we_r    <= write_enable;
                        ready_r <= 1'b0;
                        state_r <= ST_ACCESS;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!we_r) begin
                        rdata_r <= rd_byte_s;
                    end
                    ack_r   <= 1'b1;
                    oe_r    <= !we_r;
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    if (!mstr_s) begin
                        ack_r   <= 1'b0;
                        oe_r    <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ack_r   <= 1'b0;
                    oe_r    <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // GPIO register file. A pending set in the same cycle as its W1C wins.
    always_ff @(posedge CLK50 or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            out_r  <= {PAD_W{1'b0}};
            dir_r  <= {PAD_W{1'b0}};
            pend_r <= {PAD_W{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            if (wr_s && (sel_s == 2'd1)) begin
                out_r <= (out_r & ~wr_mask_vec_s) | wr_data_vec_s;
            end
            if (wr_s && (sel_s == 2'd2)) begin
                dir_r <= (dir_r & ~wr_mask_vec_s) | wr_data_vec_s;
            end
            pend_r <= (pend_r & ~clr_s) | edge_s;
            irq_r  <= |pend_r;
        end
    end

    assign data_out   = rdata_r;
    assign data_oe    = oe_r;
    assign fpga_ready = ready_r;
    assign fpga_ack   = ack_r;
    assign irq        = irq_r;
    assign pins_out   = out_r[PINS-1:0];
    assign pins_oe    = dir_r[PINS-1:0];

endmodule
